duty_soft_start: RTL
====================

Name: duty_soft_start

Overview:
Duty-cycle supervisor between the boost PID output and the H-bridge PWM generator. It soft-starts the duty ramp at power-up and clamps the duty to a safe window. In run mode it slew-limits the PID's duty updates. It also monitors the ADC output voltage and forces a latched over-voltage shutdown.

Parameters:
DUTY_MAX, 8'd230, upper clamp on duty_out
DUTY_MIN, 8'd8, lower clamp on duty_out in RUN
SS_TICKS, 16'd2700, sys_clk cycles per soft-start increment
SS_STEP, 8'd1, duty increment per soft-start tick
SLEW_MAX, 8'd8, max |change| of duty_out per duty_req_valid in RUN
OV_LIMIT, 8'd240, ADC code above which a sample counts as over-voltage
OV_COUNT, 3, consecutive over-voltage samples that trip FAULT
RETRY_TICKS, 24'd5400000, FAULT hold time before auto-retry (optional feature only)

Ports:
sys_clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  converter run request, level
duty_req  in  8  duty requested by PID
duty_req_valid  in  1  one-cycle strobe; duty_req is new
voltage  in  8  ADC output-voltage code
voltage_valid  in  1  one-cycle strobe; voltage is new
clear_fault  in  1  level; releases FAULT
duty_out  out  8  duty to PWM generator
pwm_en  out  1  1 = PWM switching allowed
fault  out  1  1 = latched over-voltage fault
state  out  2  0 IDLE, 1 SOFT_START, 2 RUN, 3 FAULT

Behaviour:
- Reset: rst_n (asynchronous, active-low) on clock sys_clk.
- Reset values: duty_out=0, pwm_en=0, fault=0, state=IDLE, tick counter=0, ov counter=0.
- All outputs are registered. Every state or duty change appears on the sys_clk edge after the causing input is sampled (latency 1).
- target = duty_req clamped to [DUTY_MIN, DUTY_MAX]. target is combinational from the current duty_req.
- IDLE:
  - duty_out=0, pwm_en=0.
  - enable=1 -> SOFT_START; tick counter cleared.
- SOFT_START:
  - pwm_en=1.
  - Tick counter counts 0..SS_TICKS-1 and wraps.
  - On each wrap: duty_out <= min(duty_out+SS_STEP, target). Use 9-bit saturating add; no 8-bit wrap.
  - On the cycle duty_out >= target (sampled each clock): -> RUN.
  - duty_req_valid does not otherwise change duty_out here.
- RUN:
  - pwm_en=1.
  - On duty_req_valid: d = target - duty_out (signed 9-bit).
    - duty_out <= duty_out + clamp(d, -SLEW_MAX, +SLEW_MAX).
    - duty_out never leaves [DUTY_MIN, DUTY_MAX].
  - Without duty_req_valid, duty_out holds.
- Over-voltage monitor (SOFT_START and RUN only; held at 0 in IDLE and FAULT):
  - On voltage_valid with voltage > OV_LIMIT: ov counter increments, saturating at OV_COUNT.
  - On voltage_valid with voltage <= OV_LIMIT: ov counter clears.
  - voltage == OV_LIMIT is not over-voltage.
  - Counter reaches OV_COUNT -> FAULT on the same edge the counter update takes effect.
- FAULT:
  - duty_out=0, pwm_en=0, fault=1.
  - clear_fault=1 and enable=0 -> IDLE, fault=0.
  - clear_fault with enable=1 is ignored; fault stays latched.
- enable=0 in SOFT_START or RUN -> IDLE next edge; duty_out=0, pwm_en=0 on that edge.
- Simultaneous events, priority highest first:
  1. fault trip
  2. enable drop
  3. SOFT_START->RUN transition
  4. duty update
  - Fault trip with duty_req_valid in the same cycle: FAULT wins; the duty update is discarded.
- enable re-asserted in IDLE always restarts the soft-start from duty 0.
- Asynchronous reset in any state (mid-ramp, FAULT) returns all state to reset values immediately.

Optional Feature:
Macro DUTY_AUTO_RETRY_EN.
- Defined: FAULT runs a 24-bit hold counter. After RETRY_TICKS cycles in FAULT, it goes to IDLE with fault=0 if enable=1 (which then restarts soft-start). clear_fault still works as in base mode. The hold counter clears on FAULT entry.
- Not defined: no hold counter; FAULT is left only via clear_fault with enable=0.

Test Plan:
- Reset then enable=1, duty_req=100 steady, SS_TICKS=2700:
  - duty_out increments by 1 every 2700 cycles.
  - state=RUN the cycle after duty_out reaches 100 (~270000 cycles); pwm_en=1 throughout.
- In RUN at duty 100: duty_req_valid with duty_req=130 -> duty_out 108, 116, 124, 130 on four successive strobes. Then duty_req=250 strobes -> saturates at 230.
- In RUN: voltage_valid with voltage 241, 241, 241 -> FAULT after the third strobe; duty_out=0, pwm_en=0, fault=1.
  - Sequence 241, 240, 241, 241 -> no fault (counter cleared by 240).
- In FAULT: clear_fault=1 with enable=1 -> stays FAULT. Then enable=0 -> IDLE, fault=0. Re-enable -> ramp restarts from 0.
- Mid-ramp at duty 40: enable=0 -> IDLE next edge, duty_out=0. Mid-ramp, assert rst_n=0 asynchronously -> all outputs 0 without a clock edge.
- Same-cycle third over-voltage strobe and duty_req_valid -> FAULT, duty_out=0. With DUTY_AUTO_RETRY_EN (RETRY_TICKS reduced to 100) and enable=1 -> IDLE after 100 cycles, then SOFT_START.

Source files
------------

// File: rtl/duty_soft_start_if.sv
// Signal bundle between the PID/ADC side and the duty supervisor.
// master drives requests and samples; slave is the supervisor.
interface duty_soft_start_if;
    logic       enable;
    logic [7:0] duty_req;
    logic       duty_req_valid;
    logic [7:0] voltage;
    logic       voltage_valid;
    logic       clear_fault;
    logic [7:0] duty_out;
    logic       pwm_en;
    logic       fault;
    logic [1:0] state;

    modport master (
        output enable, duty_req, duty_req_valid, voltage, voltage_valid, clear_fault,
        input  duty_out, pwm_en, fault, state
    );

    modport slave (
        input  enable, duty_req, duty_req_valid, voltage, voltage_valid, clear_fault,
        output duty_out, pwm_en, fault, state
    );
endinterface

// File: rtl/duty_soft_start.sv
// Duty supervisor: soft-start ramp, run-mode slew limit, latched over-voltage trip.
// Define DUTY_AUTO_RETRY_EN to leave FAULT automatically after RETRY_TICKS cycles.
module duty_soft_start #(
    parameter logic [7:0]  DUTY_MAX = 8'd230,
    parameter logic [7:0]  DUTY_MIN = 8'd8,
    parameter logic [15:0] SS_TICKS = 16'd2700,
    parameter logic [7:0]  SS_STEP  = 8'd1,
    parameter logic [7:0]  SLEW_MAX = 8'd8,
    parameter logic [7:0]  OV_LIMIT = 8'd240,
    parameter int unsigned OV_COUNT = 3
`ifdef DUTY_AUTO_RETRY_EN
    , parameter logic [23:0] RETRY_TICKS = 24'd5400000
`endif
) (
    input logic               sys_clk,
    input logic               rst_n,
    duty_soft_start_if.slave  bus
);
    localparam int unsigned OVW = $clog2(OV_COUNT + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SOFT_START = 2'd1,
        RUN        = 2'd2,
        FAULT      = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      duty_q, duty_d;
    logic [15:0]     tick_q, tick_d;
    logic [OVW-1:0]  ov_q, ov_d;
    logic            pwm_en_q, fault_q;
`ifdef DUTY_AUTO_RETRY_EN
    logic [23:0]     hold_q, hold_d;
`endif

    logic [7:0]        target;
    logic              over, trip, tick_wrap;
    logic [8:0]        ss_sum;
    logic [7:0]        ss_inc;
    logic signed [8:0] diff, slew, step;
    logic signed [9:0] run_sum;
    logic [7:0]        run_next;

    always_comb begin
        if (bus.duty_req < DUTY_MIN)      target = DUTY_MIN;
        else if (bus.duty_req > DUTY_MAX) target = DUTY_MAX;
        else                              target = bus.duty_req;

        over      = bus.voltage_valid && (bus.voltage > OV_LIMIT);
        trip      = over && (ov_q == OVW'(OV_COUNT - 1));
        tick_wrap = (tick_q == SS_TICKS - 16'd1);

        // 9-bit sum so a large step saturates at target instead of wrapping
        ss_sum = {1'b0, duty_q} + {1'b0, SS_STEP};
        ss_inc = (ss_sum > {1'b0, target}) ? target : ss_sum[7:0];

        diff = $signed({1'b0, target}) - $signed({1'b0, duty_q});
        slew = $signed({1'b0, SLEW_MAX});
        if (diff > slew)       step = slew;
        else if (diff < -slew) step = -slew;
        else                   step = diff;
        run_sum = $signed({2'b00, duty_q}) + $signed({step[8], step});
        if (run_sum < $signed({2'b00, DUTY_MIN}))      run_next = DUTY_MIN;
        else if (run_sum > $signed({2'b00, DUTY_MAX})) run_next = DUTY_MAX;
        else                                            run_next = run_sum[7:0];
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tick_d  = tick_q;
        ov_d    = ov_q;
`ifdef DUTY_AUTO_RETRY_EN
        hold_d  = hold_q;
`endif
        unique case (state_q)
            IDLE: begin
                duty_d = '0;
                tick_d = '0;
                ov_d   = '0;
                if (bus.enable) state_d = SOFT_START;
            end
            SOFT_START, RUN: begin
                if (bus.voltage_valid) ov_d = over ? ov_q + OVW'(1) : '0;
                // priority: trip, enable drop, ramp completion, duty update
                if (trip) begin
                    state_d = FAULT;
                    duty_d  = '0;
                    ov_d    = '0;
`ifdef DUTY_AUTO_RETRY_EN
                    hold_d  = '0;
`endif
                end else if (!bus.enable) begin
                    state_d = IDLE;
                    duty_d  = '0;
                    ov_d    = '0;
                end else if (state_q == SOFT_START) begin
                    tick_d = tick_wrap ? '0 : tick_q + 16'd1;
                    if (duty_q >= target) state_d = RUN;
                    else if (tick_wrap)   duty_d  = ss_inc;
                end else if (bus.duty_req_valid) begin
                    duty_d = run_next;
                end
            end
            FAULT: begin
                duty_d = '0;
                ov_d   = '0;
`ifdef DUTY_AUTO_RETRY_EN
                if (hold_q != RETRY_TICKS - 24'd1) hold_d = hold_q + 24'd1;
                if (bus.clear_fault && !bus.enable)                      state_d = IDLE;
                else if (bus.enable && (hold_q == RETRY_TICKS - 24'd1)) state_d = IDLE;
`else
                if (bus.clear_fault && !bus.enable) state_d = IDLE;
`endif
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            duty_q   <= '0;
            tick_q   <= '0;
            ov_q     <= '0;
            pwm_en_q <= 1'b0;
            fault_q  <= 1'b0;
`ifdef DUTY_AUTO_RETRY_EN
            hold_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            tick_q   <= tick_d;
            ov_q     <= ov_d;
            pwm_en_q <= (state_d == SOFT_START) || (state_d == RUN);
            fault_q  <= (state_d == FAULT);
`ifdef DUTY_AUTO_RETRY_EN
            hold_q   <= hold_d;
`endif
        end
    end

    assign bus.duty_out = duty_q;
    assign bus.pwm_en   = pwm_en_q;
    assign bus.fault    = fault_q;
    assign bus.state    = state_q;
endmodule
